term_line_engine: RTL
=====================

Name: term_line_engine

Overview:
Parametrised terminal core between the UART receiver/transmitter and the dual-port character VRAM read by the 80x30 DVI text renderer. It turns received bytes into an edited command line: typed characters are written at a hardware cursor, backspace edits the line, wrap and scroll are handled, and CR emits the completed line on a command stream. After each command it sends a prompt over UART TX and draws it on screen; scrolling is a ring-row offset (top_row) consumed by the renderer.

Parameters:
COLS, 80, visible columns; COLS <= 2**COL_W
ROWS, 30, visible rows; ROWS <= 2**ROW_W
COL_W, 7, column field width in vram_addr
ROW_W, 5, row field width in vram_addr
LINE_LEN, 64, maximum command length in bytes (1..255)
PROMPT_LEN, 2, prompt length in bytes; PROMPT_LEN < COLS
PROMPT, "> ", prompt text, 8*PROMPT_LEN bits, first byte in MSBs

Ports:
clk  in  1  system/pixel clock
btn_rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  byte to UART TX
tx_valid  out  1  TX request; held until tx_ready
tx_ready  in  1  TX accepts; transfer when tx_valid & tx_ready
vram_we  out  1  VRAM write strobe
vram_addr  out  ROW_W+COL_W  {phys_row, col}
vram_data  out  8  character code
cmd_data  out  8  command byte
cmd_valid  out  1  command beat valid
cmd_last  out  1  final byte of command
cmd_ready  in  1  consumer accepts beat
top_row  out  ROW_W  physical row shown at screen top
busy  out  1  state != IDLE
overrun  out  1  sticky: byte received while busy (dropped)

Behaviour:
- Reset (async, btn_rst_n low): all outputs 0 except vram_data=0x20 and busy=1; cursor (cur_row, cur_col)=0, used_rows=1, line count=0; state INIT.
- States: INIT, IDLE, WRAP, CLEAR_ROW, CMD_OUT, PROMPT, ECHO.
- INIT: clear physical row 0 (COLS space writes, one per cycle), then PROMPT.
- IDLE, rx_valid:
  - 0x20..0x7E: if count < LINE_LEN, store at line[count], count++, one-cycle VRAM write at cursor, cur_col++. If cur_col reaches COLS, go to WRAP. If count == LINE_LEN, drop silently.
  - 0x08 or 0x7F: if count > 0 and cur_col > 0, count--, cur_col--, write 0x20 at the new cursor. Otherwise ignore.
  - 0x0D: set a cr flag, then WRAP.
  - 0x0A and all other codes: ignored.
- rx_valid in any state other than IDLE: byte dropped, overrun <= 1 until reset.
- WRAP (1 cycle): cur_col <= 0; cur_row <= (cur_row+1) mod ROWS. If used_rows == ROWS, top_row <= (top_row+1) mod ROWS; otherwise used_rows++. Next state is CLEAR_ROW.
- CLEAR_ROW: write 0x20 to columns 0..COLS-1 of cur_row, one per cycle (exactly COLS cycles). Then:
  - cr set and count > 0: CMD_OUT.
  - cr set and count == 0: PROMPT.
  - otherwise: IDLE.
- CMD_OUT: stream line[0..count-1] with valid/ready handshake. cmd_last is asserted on the count-1 beat. cmd_valid and cmd_data are held stable while cmd_ready is low. After the last transfer: count <= 0, cr <= 0, go to PROMPT.
- PROMPT: send the PROMPT bytes in order over TX. On each transfer, write the same byte to VRAM at the cursor and advance cur_col. After the last byte, go to IDLE.
- TX rule: tx_valid never drops without a transfer; tx_data is stable while tx_valid is high.
- Arithmetic: all row/column increments wrap modulo ROWS/COLS explicitly, not modulo 2**W. vram_addr = {cur_row, cur_col}.
- Only one VRAM write per cycle. vram_we is low in all cycles that have no write.

Optional Feature:
TERM_ECHO_EN.
- Defined: each accepted printable byte, and each effective backspace, enters ECHO after its VRAM write and sends the byte on TX (backspace sends 0x08,0x20,0x08). CR sends 0x0D,0x0A before WRAP. Dropped or ignored bytes are not echoed.
- Undefined: the ECHO state is absent, and TX carries only prompts.

Test Plan:
- Reset, tx_ready=1 -> 80 space writes to row 0, then TX bytes 0x3E,0x20 with VRAM writes at addr {0,0},{0,1}; busy falls; cursor col=2.
- Type "ls",CR with cmd_ready=1 -> VRAM 'l'@{0,2}, 's'@{0,3}; WRAP to row 1; 80 clears; cmd beats 0x6C, 0x73 (cmd_last on 0x73); prompt drawn at {1,0},{1,1}.
- Type "ab", 0x08, CR -> VRAM space written @{0,3}; exactly one cmd beat 0x61 with cmd_last=1.
- Issue 30 empty CRs after reset -> top_row goes 0 to 1 on the 30th WRAP; cur_row=0; row 0 cleared.
- Hold cmd_ready=0 for 10 cycles during CMD_OUT, send rx_valid -> cmd_data stable; byte dropped; overrun=1; stream resumes intact.
- Type 65 printable bytes with LINE_LEN=64 -> 64 VRAM writes; 65th ignored; cmd stream length 64 after CR.

Source files
------------

// File: rtl/term_line_engine.sv
// term_line_engine: UART line editor feeding character VRAM, a command stream and a TX prompt.
// Define TERM_ECHO_EN to echo accepted keystrokes on TX.
module term_line_engine #(
    parameter int COLS       = 80,
    parameter int ROWS       = 30,
    parameter int COL_W      = 7,
    parameter int ROW_W      = 5,
    parameter int LINE_LEN   = 64,
    parameter int PROMPT_LEN = 2,
    parameter logic [8*PROMPT_LEN-1:0] PROMPT = "> "
) (
    input  logic                   clk,
    input  logic                   btn_rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   vram_we,
    output logic [ROW_W+COL_W-1:0] vram_addr,
    output logic [7:0]             vram_data,
    output logic [7:0]             cmd_data,
    output logic                   cmd_valid,
    output logic                   cmd_last,
    input  logic                   cmd_ready,
    output logic [ROW_W-1:0]       top_row,
    output logic                   busy,
    output logic                   overrun
);
    localparam int LW = LINE_LEN > 1 ? $clog2(LINE_LEN) : 1;
    localparam int IW = COL_W > 8 ? COL_W : 8;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [ROW_W:0]   USED_MAX = (ROW_W+1)'(ROWS);
    localparam logic [7:0]       LMAX     = 8'(LINE_LEN);
    localparam logic [IW-1:0]    CLR_END  = IW'(COLS - 1);
    localparam logic [IW-1:0]    P_END    = IW'(PROMPT_LEN - 1);
    localparam logic [7:0]       SP       = 8'h20;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_WRAP, S_CLEAR_ROW, S_CMD_OUT, S_PROMPT, S_ECHO} state_t;

    state_t                 r_state, w_state;
    logic [ROW_W-1:0]       r_cur_row, w_cur_row, r_top, w_top, w_row_inc, w_top_inc;
    logic [ROW_W:0]         r_used, w_used;
    logic [COL_W-1:0]       r_cur_col, w_cur_col, w_col_inc, w_wcol;
    logic [7:0]             r_count, w_count, w_wdata, w_pbyte;
    logic [IW-1:0]          r_idx, w_idx;
    logic                   r_cr, w_cr, w_we, w_line_we, w_printable, w_bs, w_last_beat;
    logic                   r_overrun, r_vram_we;
    logic [ROW_W+COL_W-1:0] r_vram_addr;
    logic [7:0]             r_vram_data;
    logic [7:0]             r_line [LINE_LEN];
`ifdef TERM_ECHO_EN
    logic [23:0]            r_echo, w_echo;
    logic [1:0]             r_echo_n, w_echo_n;
    state_t                 r_ret, w_ret;
`endif

    assign w_col_inc   = r_cur_col == LAST_COL ? '0 : r_cur_col + 1'b1;
    assign w_row_inc   = r_cur_row == LAST_ROW ? '0 : r_cur_row + 1'b1;
    assign w_top_inc   = r_top == LAST_ROW ? '0 : r_top + 1'b1;
    assign w_printable = rx_data >= 8'h20 && rx_data <= 8'h7E;
    assign w_bs        = (rx_data == 8'h08 || rx_data == 8'h7F) && r_count != 8'd0 && r_cur_col != '0;
    assign w_last_beat = r_idx + 1'b1 == IW'(r_count);
    assign w_pbyte     = 8'(PROMPT >> (8 * (PROMPT_LEN - 1 - int'(r_idx))));

`ifdef TERM_ECHO_EN
    assign tx_valid = r_state == S_PROMPT || r_state == S_ECHO;
    assign tx_data  = !tx_valid ? 8'h00 : r_state == S_ECHO ? r_echo[23:16] : w_pbyte;
`else
    assign tx_valid = r_state == S_PROMPT;
    assign tx_data  = tx_valid ? w_pbyte : 8'h00;
`endif
    assign cmd_valid = r_state == S_CMD_OUT;
    assign cmd_data  = cmd_valid ? r_line[r_idx[LW-1:0]] : 8'h00;
    assign cmd_last  = cmd_valid && w_last_beat;
    assign vram_we   = r_vram_we;
    assign vram_addr = r_vram_addr;
    assign vram_data = r_vram_data;
    assign top_row   = r_top;
    assign busy      = r_state != S_IDLE;
    assign overrun   = r_overrun;

    always_comb begin
        w_state   = r_state;
        w_cur_row = r_cur_row;
        w_cur_col = r_cur_col;
        w_used    = r_used;
        w_top     = r_top;
        w_count   = r_count;
        w_cr      = r_cr;
        w_idx     = r_idx;
        w_we      = 1'b0;
        w_wcol    = r_cur_col;
        w_wdata   = SP;
        w_line_we = 1'b0;
`ifdef TERM_ECHO_EN
        w_echo    = r_echo;
        w_echo_n  = r_echo_n;
        w_ret     = r_ret;
`endif
        case (r_state)
            S_INIT, S_CLEAR_ROW: begin
                w_we   = 1'b1;
                w_wcol = r_idx[COL_W-1:0];
                w_idx  = r_idx + 1'b1;
                if (r_idx == CLR_END) begin
                    w_idx   = '0;
                    w_state = (r_state == S_INIT || (r_cr && r_count == 8'd0)) ? S_PROMPT
                            : r_cr ? S_CMD_OUT : S_IDLE;
                    if (r_count == 8'd0) w_cr = 1'b0;
                end
            end
            S_IDLE: if (rx_valid) begin
                if (w_printable) begin
                    if (r_count < LMAX) begin
                        w_line_we = 1'b1;
                        w_count   = r_count + 1'b1;
                        w_we      = 1'b1;
                        w_wdata   = rx_data;
                        w_cur_col = w_col_inc;
                        w_state   = r_cur_col == LAST_COL ? S_WRAP : S_IDLE;
                    end
                end else if (w_bs) begin
                    w_count   = r_count - 1'b1;
                    w_cur_col = r_cur_col - 1'b1;
                    w_wcol    = r_cur_col - 1'b1;
                    w_we      = 1'b1;
                end else if (rx_data == 8'h0D) begin
                    w_cr    = 1'b1;
                    w_state = S_WRAP;
                end
`ifdef TERM_ECHO_EN
                if (w_we || w_cr) begin
                    w_ret    = w_state;
                    w_state  = S_ECHO;
                    w_echo   = w_bs ? 24'h082008 : rx_data == 8'h0D ? 24'h0D0A00 : {rx_data, 16'h0000};
                    w_echo_n = w_bs ? 2'd3 : rx_data == 8'h0D ? 2'd2 : 2'd1;
                end
`endif
            end
            S_WRAP: begin
                w_cur_col = '0;
                w_cur_row = w_row_inc;
                w_idx     = '0;
                w_state   = S_CLEAR_ROW;
                if (r_used == USED_MAX) w_top = w_top_inc;
                else w_used = r_used + 1'b1;
            end
            S_CMD_OUT: if (cmd_ready) begin
                w_idx = r_idx + 1'b1;
                if (w_last_beat) begin
                    w_idx   = '0;
                    w_count = 8'd0;
                    w_cr    = 1'b0;
                    w_state = S_PROMPT;
                end
            end
            S_PROMPT: if (tx_ready) begin
                w_we      = 1'b1;
                w_wdata   = w_pbyte;
                w_cur_col = w_col_inc;
                w_idx     = r_idx == P_END ? '0 : r_idx + 1'b1;
                if (r_idx == P_END) w_state = S_IDLE;
            end
`ifdef TERM_ECHO_EN
            S_ECHO: if (tx_ready) begin
                w_echo   = r_echo << 8;
                w_echo_n = r_echo_n - 1'b1;
                if (r_echo_n == 2'd1) w_state = r_ret;
            end
`endif
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge btn_rst_n) begin
        if (!btn_rst_n) begin
            r_state     <= S_INIT;
            r_cur_row   <= '0;
            r_cur_col   <= '0;
            r_used      <= (ROW_W+1)'(1);
            r_top       <= '0;
            r_count     <= 8'd0;
            r_cr        <= 1'b0;
            r_idx       <= '0;
            r_overrun   <= 1'b0;
            r_vram_we   <= 1'b0;
            r_vram_addr <= '0;
            r_vram_data <= SP;
`ifdef TERM_ECHO_EN
            r_echo      <= '0;
            r_echo_n    <= '0;
            r_ret       <= S_IDLE;
`endif
        end else begin
            r_state     <= w_state;
            r_cur_row   <= w_cur_row;
            r_cur_col   <= w_cur_col;
            r_used      <= w_used;
            r_top       <= w_top;
            r_count     <= w_count;
            r_cr        <= w_cr;
            r_idx       <= w_idx;
            r_overrun   <= r_overrun | (rx_valid && r_state != S_IDLE);
            r_vram_we   <= w_we;
            r_vram_addr <= {r_cur_row, w_wcol};
            r_vram_data <= w_wdata;
`ifdef TERM_ECHO_EN
            r_echo      <= w_echo;
            r_echo_n    <= w_echo_n;
            r_ret       <= w_ret;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (w_line_we) r_line[r_count[LW-1:0]] <= rx_data;
    end
endmodule
